alu_share_ctl: RTL

ALU_SHARE_CTL -- requirements
Module: alu_share_ctl

---
 rtl/alu_ctl_pkg.sv | 32 +++
 rtl/alu_rr_pick.sv | 16 +
 rtl/alu_share_ctl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctl_pkg.sv
// Shared definitions for the two-port ALU sharing controller:
// op-code constants, FSM state type and small helpers.
package alu_ctl_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'd0;
  localparam logic [OP_W-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_NAND = 4'd6;
  localparam logic [OP_W-1:0] OP_INV  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Only arithmetic ops produce a meaningful overflow flag.
  function automatic logic op_has_ovfl(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Requester index to one-hot port vector.
  function automatic logic [1:0] idx_to_oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: rr names the preferred port on a tie,
// a lone valid request always wins. Output is one-hot or zero.
module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] gnt
);

  // Tie broken by rr; a single valid requester wins unconditionally.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = valid[0] & (~valid[1] | ~rr);
    gnt[1] = valid[1] & (~valid[0] |  rr);
  end

endmodule

// File: rtl/alu_share_ctl.sv
// Shares one external combinational ALU between two requesters.
// IDLE grants one request (round-robin), EXEC drives the ALU for one
// cycle and captures its result, RESP holds the response until acked.
// Optional feature: define ALU_SHARE_CTL_OPCHECK_EN to reject op codes
// 8..15 with rsp_err (skips EXEC, ALU left idle).
module alu_share_ctl
  import alu_ctl_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic signed [DW-1:0] req0_a,
  input  logic signed [DW-1:0] req0_b,
  input  logic [3:0]           req0_op,
  input  logic signed [DW-1:0] req1_a,
  input  logic signed [DW-1:0] req1_b,
  input  logic [3:0]           req1_op,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [DW-1:0]        rsp_r,
  output logic                 rsp_zero,
  output logic                 rsp_neg,
  output logic                 rsp_ovfl,
  output logic                 rsp_err,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [3:0]           alu_op,
  input  logic [DW-1:0]        alu_r,
  input  logic                 alu_zero,
  input  logic                 alu_neg,
  input  logic                 alu_ovfl
);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gnt_idx_q, gnt_idx_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DW-1:0]     alu_a_q, alu_a_d;
  logic [DW-1:0]     alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_r_q, rsp_r_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_neg_q, rsp_neg_d;
  logic              rsp_ovfl_q, rsp_ovfl_d;

  logic [1:0]        pick_gnt;
  logic              acc;
  logic              acc_idx;
  logic [DW-1:0]     acc_a;
  logic [DW-1:0]     acc_b;
  logic [OP_W-1:0]   acc_op;
  logic              bad_op;

  alu_rr_pick u_rr_pick (
    .valid (req_valid),
    .rr    (rr_q),
    .gnt   (pick_gnt)
  );

  // Ready only in IDLE and never while reset is asserted.
  assign req_ready = (state_q == ST_IDLE && !rst) ? pick_gnt : 2'b00;
  assign acc       = |req_ready;
  assign acc_idx   = req_ready[1];
  assign acc_a     = acc_idx ? req1_a  : req0_a;
  assign acc_b     = acc_idx ? req1_b  : req0_b;
  assign acc_op    = acc_idx ? req1_op : req0_op;

`ifdef ALU_SHARE_CTL_OPCHECK_EN
  assign bad_op = acc_op[3];
`else
  assign bad_op = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (acc) state_d = bad_op ? ST_RESP : ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready[gnt_idx_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_SHARE_CTL_OPCHECK_EN
  logic rsp_err_q, rsp_err_d;
`endif

  // FSM output / datapath next values; ALU inputs are zero outside EXEC.
  always_comb begin
    rr_d        = rr_q;
    gnt_idx_d   = gnt_idx_q;
    op_d        = op_q;
    alu_a_d     = '0;
    alu_b_d     = '0;
    alu_op_d    = '0;
    rsp_valid_d = 2'b00;
    rsp_r_d     = rsp_r_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_ovfl_d  = rsp_ovfl_q;
`ifdef ALU_SHARE_CTL_OPCHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          gnt_idx_d = acc_idx;
          op_d      = acc_op;
          if (bad_op) begin
            rsp_r_d     = '0;
            rsp_zero_d  = 1'b1;
            rsp_neg_d   = 1'b0;
            rsp_ovfl_d  = 1'b0;
            rsp_valid_d = idx_to_oh(acc_idx);
`ifdef ALU_SHARE_CTL_OPCHECK_EN
            rsp_err_d   = 1'b1;
`endif
          end else begin
            alu_a_d  = acc_a;
            alu_b_d  = acc_b;
            alu_op_d = acc_op;
          end
        end
      end
      ST_EXEC: begin
        rsp_r_d     = alu_r;
        rsp_zero_d  = alu_zero;
        rsp_neg_d   = alu_neg;
        rsp_ovfl_d  = alu_ovfl & op_has_ovfl(op_q);
        rsp_valid_d = idx_to_oh(gnt_idx_q);
`ifdef ALU_SHARE_CTL_OPCHECK_EN
        rsp_err_d   = 1'b0;
`endif
      end
      ST_RESP: begin
        if (rsp_ready[gnt_idx_q]) rr_d = ~gnt_idx_q;
        else                      rsp_valid_d = rsp_valid_q;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= 1'b0;
      gnt_idx_q   <= 1'b0;
      op_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_r_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_ovfl_q  <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      gnt_idx_q   <= gnt_idx_d;
      op_q        <= op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_ovfl_q  <= rsp_ovfl_d;
    end
  end

`ifdef ALU_SHARE_CTL_OPCHECK_EN
  // Error flag for rejected op codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_err_q <= 1'b0;
    else     rsp_err_q <= rsp_err_d;
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_ovfl  = rsp_ovfl_q;

endmodule
